// File: rtl/ofdm_sc_frame_detector.sv
// ofdm_sc_frame_detector
// Schmidl-Cox frame detector. Joins the correlation P(d), power R(d) and
// delayed-sample streams, tests |P|^2 >= thr * R^2 exactly, qualifies a
// plateau of programmable minimum length, then gates one frame of samples
// (with tlast) to the output. The peak correlation of each plateau goes out
// on a side stream for coarse CFO estimation.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   clear                 flush to SEARCH; settings and overflow_cnt kept
//   set_stb/addr/data     settings bus (thr, min_plateau, frame_len, holdoff, mode)
//   i_corr_*              {I,Q} signed P(d) stream
//   i_power_*             unsigned R(d) stream
//   i_samples_*           delayed sample stream
//   o_t*                  gated sample output with tlast
//   o_peak_*              {I,Q} of P at the max |P|^2 of the last plateau
//   sof, eof              pulses on first/last frame beat handshake
//   overflow_cnt          saturating count of peak values overwritten unread
module ofdm_sc_frame_detector #(
  parameter int CORR_WIDTH   = 22,
  parameter int POWER_WIDTH  = 22,
  parameter int SAMPLE_WIDTH = 32,
  parameter int THRESH_WIDTH = 16,
  parameter int SR_BASE      = 0,
  parameter logic [THRESH_WIDTH-1:0] DEFAULT_THRESH = 16'h8000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      set_stb,
  input  logic [7:0]                set_addr,
  input  logic [31:0]               set_data,
  input  logic [2*CORR_WIDTH-1:0]   i_corr_tdata,
  input  logic                      i_corr_tvalid,
  output logic                      i_corr_tready,
  input  logic [POWER_WIDTH-1:0]    i_power_tdata,
  input  logic                      i_power_tvalid,
  output logic                      i_power_tready,
  input  logic [SAMPLE_WIDTH-1:0]   i_samples_tdata,
  input  logic                      i_samples_tvalid,
  output logic                      i_samples_tready,
  output logic [SAMPLE_WIDTH-1:0]   o_tdata,
  output logic                      o_tlast,
  output logic                      o_tvalid,
  input  logic                      o_tready,
  output logic [2*CORR_WIDTH-1:0]   o_peak_tdata,
  output logic                      o_peak_tvalid,
  input  logic                      o_peak_tready,
  output logic                      sof,
  output logic                      eof,
  output logic [15:0]               overflow_cnt
);

  localparam int MAG_W = 2*CORR_WIDTH + 1;
  localparam int PSQ_W = 2*POWER_WIDTH;
  localparam int LHS_W = MAG_W + THRESH_WIDTH;
  localparam int RHS_W = PSQ_W + THRESH_WIDTH;
  localparam int CMP_W = (LHS_W > RHS_W) ? LHS_W : RHS_W;
  localparam logic [7:0] A_THR  = 8'(SR_BASE);
  localparam logic [7:0] A_MINP = 8'(SR_BASE + 1);
  localparam logic [7:0] A_FLEN = 8'(SR_BASE + 2);
  localparam logic [7:0] A_HOLD = 8'(SR_BASE + 3);
  localparam logic [7:0] A_MODE = 8'(SR_BASE + 4);

  typedef logic signed [CORR_WIDTH-1:0]   comp_t;
  typedef logic signed [2*CORR_WIDTH-1:0] sq_t;
  typedef logic [MAG_W-1:0]               mag_t;
  typedef logic [PSQ_W-1:0]               psq_t;
  typedef logic [CMP_W-1:0]               cmp_t;
  typedef enum logic [1:0] {ST_SEARCH = 2'd0, ST_PLATEAU = 2'd1, ST_EMIT = 2'd2, ST_HOLDOFF = 2'd3} state_t;

  logic [THRESH_WIDTH-1:0] thr_r, thr_sh_r, thr_eff_s;
  logic [15:0] min_plat_r, frame_len_r, holdoff_r, min_sh_r, flen_sh_r, hold_sh_r;
  logic enable_r, passthrough_r;
  logic advance_s, join_s, beat_s, above_s, plat_ok_s, frame_end_s;
  logic start_s, grow_s, emit_first_s, emit_mid_s, hold_beat_s, fwd_s, last_s;
  logic s1_v_r, s2_v_r, s3_v_r;
  comp_t s1_i_r, s1_q_r, s2_i_r, s2_q_r, s3_i_r, s3_q_r, peak_i_r, peak_q_r;
  logic [POWER_WIDTH-1:0] s1_pwr_r;
  logic [SAMPLE_WIDTH-1:0] s1_smp_r, s2_smp_r, s3_smp_r, o_tdata_r;
  sq_t sq_i_s, sq_q_s;
  mag_t mag_s, s2_mag_r, s3_mag_r, peak_mag_r;
  psq_t psq_s, s2_psq_r, s3_psq_r;
  cmp_t s3_lhs_r, rhs_s;
  logic [15:0] plat_cnt_r, emit_cnt_r, hold_cnt_r, overflow_cnt_r;
  state_t state_r, state_nxt_s;
  logic o_tvalid_r, o_tlast_r, out_first_r, out_last_r, o_peak_tvalid_r;
  logic [2*CORR_WIDTH-1:0] o_peak_tdata_r;
  logic unused_ok_s;

  assign unused_ok_s = ^set_data[31:16];

  // Settings registers; a write is visible the cycle after set_stb.
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_r <= DEFAULT_THRESH;
      min_plat_r <= 16'd32;
      frame_len_r <= 16'd640;
      holdoff_r <= 16'd0;
      enable_r <= 1'b1;
      passthrough_r <= 1'b0;
    end else if (set_stb) begin
      case (set_addr)
        A_THR:  thr_r <= set_data[THRESH_WIDTH-1:0];
        A_MINP: min_plat_r <= set_data[15:0];
        A_FLEN: frame_len_r <= set_data[15:0];
        A_HOLD: holdoff_r <= set_data[15:0];
        A_MODE: begin
          enable_r <= set_data[0];
          passthrough_r <= set_data[1];
        end
        default: ;
      endcase
    end
  end

  // Only the output register can stall; the whole pipeline moves together.
  assign advance_s = ~o_tvalid_r | o_tready;
  assign join_s = i_corr_tvalid & i_power_tvalid & i_samples_tvalid & advance_s;
  assign i_corr_tready = join_s;
  assign i_power_tready = join_s;
  assign i_samples_tready = join_s;

  assign sq_i_s = sq_t'(s1_i_r) * sq_t'(s1_i_r);
  assign sq_q_s = sq_t'(s1_q_r) * sq_t'(s1_q_r);
  assign mag_s = mag_t'($unsigned(sq_i_s)) + mag_t'($unsigned(sq_q_s));
  assign psq_s = psq_t'(s1_pwr_r) * psq_t'(s1_pwr_r);

  // Pipeline valid bits.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      s1_v_r <= 1'b0;
      s2_v_r <= 1'b0;
      s3_v_r <= 1'b0;
    end else if (advance_s) begin
      s1_v_r <= join_s;
      s2_v_r <= s1_v_r;
      s3_v_r <= s2_v_r;
    end
  end

  // Metric pipeline: capture, square, pre-shift the |P|^2 side.
  always_ff @(posedge clk) begin
    if (advance_s) begin
      s1_i_r <= i_corr_tdata[2*CORR_WIDTH-1:CORR_WIDTH];
      s1_q_r <= i_corr_tdata[CORR_WIDTH-1:0];
      s1_pwr_r <= i_power_tdata;
      s1_smp_r <= i_samples_tdata;
      s2_i_r <= s1_i_r;
      s2_q_r <= s1_q_r;
      s2_mag_r <= mag_s;
      s2_psq_r <= psq_s;
      s2_smp_r <= s1_smp_r;
      s3_i_r <= s2_i_r;
      s3_q_r <= s2_q_r;
      s3_mag_r <= s2_mag_r;
      s3_lhs_r <= cmp_t'(s2_mag_r) << THRESH_WIDTH;
      s3_psq_r <= s2_psq_r;
      s3_smp_r <= s2_smp_r;
    end
  end

  // SEARCH compares against the live threshold; a running plateau uses the
  // copy taken on entry, which is the same value at that instant.
  assign thr_eff_s = (state_r == ST_SEARCH) ? thr_r : thr_sh_r;
  assign rhs_s = cmp_t'(thr_eff_s) * cmp_t'(s3_psq_r);
  assign above_s = (s3_psq_r != {PSQ_W{1'b0}}) && (s3_lhs_r >= rhs_s);
  assign beat_s = advance_s & s3_v_r;
  assign plat_ok_s = (plat_cnt_r >= min_sh_r);
  assign frame_end_s = (emit_cnt_r == (flen_sh_r - 16'd1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_r <= ST_SEARCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SEARCH: begin
        if (beat_s && above_s && enable_r) state_nxt_s = ST_PLATEAU;
        else state_nxt_s = ST_SEARCH;
      end
      ST_PLATEAU: begin
        if (beat_s && !above_s) begin
          if (!plat_ok_s) state_nxt_s = ST_SEARCH;
          else if (flen_sh_r != 16'd1) state_nxt_s = ST_EMIT;
          else if (hold_sh_r == 16'd0) state_nxt_s = ST_SEARCH;
          else state_nxt_s = ST_HOLDOFF;
        end else begin
          state_nxt_s = ST_PLATEAU;
        end
      end
      ST_EMIT: begin
        if (beat_s && frame_end_s) state_nxt_s = (hold_sh_r == 16'd0) ? ST_SEARCH : ST_HOLDOFF;
        else state_nxt_s = ST_EMIT;
      end
      ST_HOLDOFF: begin
        if (beat_s && (hold_cnt_r == (hold_sh_r - 16'd1))) state_nxt_s = ST_SEARCH;
        else state_nxt_s = ST_HOLDOFF;
      end
      default: state_nxt_s = ST_SEARCH;
    endcase
  end

  // Per-beat actions; the beat that ends a qualified plateau is the first frame beat.
  always_comb begin
    start_s = 1'b0;
    grow_s = 1'b0;
    emit_first_s = 1'b0;
    emit_mid_s = 1'b0;
    hold_beat_s = 1'b0;
    case (state_r)
      ST_SEARCH: start_s = beat_s & above_s & enable_r;
      ST_PLATEAU: begin
        grow_s = beat_s & above_s;
        emit_first_s = beat_s & ~above_s & plat_ok_s;
      end
      ST_EMIT: emit_mid_s = beat_s;
      ST_HOLDOFF: hold_beat_s = beat_s;
      default: start_s = 1'b0;
    endcase
    fwd_s = emit_first_s | emit_mid_s | (beat_s & passthrough_r);
    last_s = (emit_first_s & (flen_sh_r == 16'd1)) | (emit_mid_s & frame_end_s);
  end

  // Plateau/frame/holdoff counters, peak tracking and per-frame setting copies.
  always_ff @(posedge clk) begin
    if (reset) begin
      plat_cnt_r <= 16'd0;
      emit_cnt_r <= 16'd0;
      hold_cnt_r <= 16'd0;
      peak_i_r <= {CORR_WIDTH{1'b0}};
      peak_q_r <= {CORR_WIDTH{1'b0}};
      peak_mag_r <= {MAG_W{1'b0}};
      thr_sh_r <= DEFAULT_THRESH;
      min_sh_r <= 16'd32;
      flen_sh_r <= 16'd640;
      hold_sh_r <= 16'd0;
    end else begin
      if (start_s) begin
        plat_cnt_r <= 16'd1;
        peak_i_r <= s3_i_r;
        peak_q_r <= s3_q_r;
        peak_mag_r <= s3_mag_r;
        thr_sh_r <= thr_r;
        min_sh_r <= min_plat_r;
        flen_sh_r <= (frame_len_r == 16'd0) ? 16'd1 : frame_len_r;
        hold_sh_r <= holdoff_r;
      end else if (grow_s) begin
        plat_cnt_r <= (plat_cnt_r == 16'hFFFF) ? plat_cnt_r : plat_cnt_r + 16'd1;
        if (s3_mag_r > peak_mag_r) begin
          peak_i_r <= s3_i_r;
          peak_q_r <= s3_q_r;
          peak_mag_r <= s3_mag_r;
        end
      end
      if (emit_first_s) begin
        emit_cnt_r <= 16'd1;
        hold_cnt_r <= 16'd0;
      end else if (emit_mid_s) begin
        emit_cnt_r <= emit_cnt_r + 16'd1;
      end else if (hold_beat_s) begin
        hold_cnt_r <= hold_cnt_r + 16'd1;
      end
    end
  end

  // Output register; holds while o_tvalid & !o_tready.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      o_tvalid_r <= 1'b0;
      o_tlast_r <= 1'b0;
      out_first_r <= 1'b0;
      out_last_r <= 1'b0;
      o_tdata_r <= {SAMPLE_WIDTH{1'b0}};
    end else if (advance_s) begin
      o_tvalid_r <= fwd_s;
      o_tlast_r <= last_s & ~passthrough_r;
      out_first_r <= emit_first_s;
      out_last_r <= last_s;
      o_tdata_r <= s3_smp_r;
    end
  end

  // Peak side stream; an unread value is overwritten and counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_peak_tvalid_r <= 1'b0;
      o_peak_tdata_r <= {(2*CORR_WIDTH){1'b0}};
      overflow_cnt_r <= 16'd0;
    end else if (clear) begin
      o_peak_tvalid_r <= 1'b0;
    end else if (emit_first_s) begin
      o_peak_tvalid_r <= 1'b1;
      o_peak_tdata_r <= {peak_i_r, peak_q_r};
      if (o_peak_tvalid_r && !o_peak_tready && (overflow_cnt_r != 16'hFFFF))
        overflow_cnt_r <= overflow_cnt_r + 16'd1;
    end else if (o_peak_tready) begin
      o_peak_tvalid_r <= 1'b0;
    end
  end

  assign o_tdata = o_tdata_r;
  assign o_tlast = o_tlast_r;
  assign o_tvalid = o_tvalid_r;
  assign o_peak_tdata = o_peak_tdata_r;
  assign o_peak_tvalid = o_peak_tvalid_r;
  assign overflow_cnt = overflow_cnt_r;
  assign sof = o_tvalid_r & o_tready & out_first_r;
  assign eof = o_tvalid_r & o_tready & out_last_r;

endmodule

// File: doc/ofdm_sc_frame_detector.md
# ofdm_sc_frame_detector

Parametrised Schmidl-Cox frame detector for the OFDM receive chain. It consumes the joined correlation P(d), power R(d) and delayed-sample streams, evaluates |P|² ≥ thr·R² with a runtime threshold, and qualifies a plateau of programmable minimum length. It then emits one gated frame of samples with tlast, plus a side-stream carrying the peak correlation for downstream coarse-CFO estimation. It generalises fixed-parameter short-preamble detection in width, thresholding, frame length, hold-off and mode.

## Interface
- CORR_WIDTH, 22: bits per I/Q component of P(d).
- POWER_WIDTH, 22: bits of unsigned R(d).
- SAMPLE_WIDTH, 32: sample bus width (I in upper half).
- THRESH_WIDTH, 16: threshold bits, unsigned Q0.THRESH_WIDTH.
- SR_BASE, 0: base settings address.
- DEFAULT_THRESH, 16'h8000: threshold reset value (0.5).
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous flush to SEARCH; settings retained.
- set_stb / set_addr / set_data  in  1/8/32  settings bus.
- i_corr_tdata  in  2*CORR_WIDTH  {I,Q} signed; plus i_corr_tvalid (in), i_corr_tready (out).
- i_power_tdata  in  POWER_WIDTH  plus tvalid (in), tready (out).
- i_samples_tdata  in  SAMPLE_WIDTH  plus tvalid (in), tready (out).
- o_tdata/o_tlast/o_tvalid  out  SAMPLE_WIDTH/1/1; o_tready in.
- o_peak_tdata  out  2*CORR_WIDTH  {I,Q} of P at max |P|²; o_peak_tvalid out, o_peak_tready in.
- sof, eof  out  1  one-cycle pulses on first/last output handshake.
- overflow_cnt  out  16  saturating count of overwritten peak values.

## Operation
- Registers: SR_BASE+0 thr[THRESH_WIDTH-1:0]; +1 min_plateau[15:0] (reset 32); +2 frame_len[15:0] (reset 640, 0 treated as 1); +3 holdoff[15:0] (reset 0); +4 bit0 enable (reset 1), bit1 passthrough (reset 0). Other addresses ignored.
- Join: one beat consumed when all three inputs valid and pipeline advances; all three treadys equal that condition.
- Metric: magsq = I²+Q² (2*CORR_WIDTH+1 bits, exact); psq = R² (2*POWER_WIDTH bits); above = (R≠0) && (magsq<<THRESH_WIDTH ≥ thr·psq), full-width, no rounding.
- Settings shadowed on each SEARCH→PLATEAU transition; writes mid-frame apply to next frame.
- States:
  - SEARCH: drop samples; above & enable → PLATEAU, cnt=1, peak=P, peakmag=magsq.
  - PLATEAU: drop samples; above → cnt++ (saturate 65535), update peak if magsq > peakmag (strict; first max kept); !above & cnt<min_plateau → SEARCH; !above & cnt≥min_plateau → EMIT, load o_peak, current sample is emitted as first beat.
  - EMIT: forward frame_len samples; last has o_tlast=1; → HOLDOFF (holdoff=0 → SEARCH).
  - HOLDOFF: drop holdoff samples; → SEARCH.
- Passthrough=1: all samples forwarded, o_tlast never set, state machine still runs; sof/eof/o_peak behave as normal.
- o_peak: registered; if still valid when a new peak loads, overwrite and increment overflow_cnt (saturating).
- clear: state→SEARCH, pipeline/output valids cleared, o_peak_tvalid cleared; counters and settings kept.

## Timing
- Pipeline: 3 metric stages + 1 output register; first output beat 4 cycles after the join handshake of that sample.
- Advance = !o_tvalid | o_tready. In non-emit states, output stage discards, so stall only occurs in EMIT/passthrough.
- o_tdata/o_tlast stable while o_tvalid & !o_tready.
- sof/eof asserted in the cycle of the corresponding handshake; both in same cycle if frame_len=1.
- Settings write takes effect the cycle after set_stb.
- Reset values: all tvalids, tlast, sof, eof 0; overflow_cnt 0; state SEARCH; registers at stated defaults. Reset mid-frame terminates output without tlast.

## Test plan
- P=(1000,0), R=1000, thr=0.5, min_plateau=32, 40 above beats then below → one frame of 640 beats, tlast on 640th, sof/eof once each, o_peak=(1000,0).
- Plateau of 31 beats with min_plateau=32 → no output, no sof, state back to SEARCH.
- R=0 with P=(0,0) and with P=(5,5) → never above; no frame.
- Random o_tready (50%) during EMIT → 640 beats in order, no drops/duplicates, inputs stall accordingly.
- Two frames with o_peak_tready=0 → second overwrites, overflow_cnt=1; holdoff=100 suppresses a plateau starting 50 beats after first tlast.
- clear asserted mid-EMIT → o_tvalid 0 next cycle, no eof, next plateau detected normally.
